// File: rtl/riscv_pkg.sv
// Core-wide constants shared by the integer register file and its users.
//   RV_XLEN    : integer data width
//   RV_NREGS   : number of architectural integer registers
//   RV_REG_AW  : register address width
//   RV_X0_IDX  : index of the hardwired-zero register
//   RV_SP_IDX  : index of the stack-pointer register
//   MEM_DEPTH  : data memory depth in bytes
//   SP_RESET   : stack-pointer reset value (top of memory window)
package riscv_pkg;

    localparam int unsigned RV_XLEN   = 32;
    localparam int unsigned RV_NREGS  = 32;
    localparam int unsigned RV_REG_AW = $clog2(RV_NREGS);
    localparam int unsigned RV_X0_IDX = 0;
    localparam int unsigned RV_SP_IDX = 2;

    localparam logic [RV_XLEN-1:0] MEM_DEPTH = 32'h0001_0000;
    localparam logic [RV_XLEN-1:0] SP_RESET  = MEM_DEPTH + 32'h0100_0000;

endpackage

// File: rtl/reg_pend_counter.sv
// Saturating up/down counter tracking in-flight writes to one register.
//   clock, reset : rising-edge clock, async active-high reset
//   inc          : one write issued to this register
//   dec          : one write retired from this register
//   count        : current pending count
//   at_max       : count is saturated, a lone inc is ignored
//   nonzero      : count > 0
//   underflow    : dec arrives while count is zero
module reg_pend_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         at_max,
    output logic         nonzero,
    output logic         underflow
);

    localparam logic [W-1:0] CNT_MAX = '1;

    assign at_max    = (count == CNT_MAX);
    assign nonzero   = |count;
    // Any retire against an empty counter is an error, even if a same-cycle
    // issue leaves the count unchanged.
    assign underflow = dec && !nonzero;

    // Simultaneous inc and dec cancel; otherwise clamp at both ends.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec && !at_max) begin
            count <= count + W'(1);
        end else if (dec && !inc && nonzero) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write integer register file with write-to-read bypass and a
// per-register pending-write scoreboard used by decode to detect hazards.
//   clock, reset        : rising-edge clock, async active-high reset
//   addr_rs1/addr_rs2   : read addresses
//   data_rs1/data_rs2   : combinational read data (bypassed from writeback)
//   busy_rs1/busy_rs2   : register still has a pending write after this cycle's retire
//   issue_valid/ready   : decode issues a write to addr_issue; ready=0 when saturated
//   write_enable        : writeback commits data_rd to addr_rd and retires one pending write
//   pend_err            : sticky flag, a retire hit an empty counter
module regfile_scoreboard
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN    = RV_XLEN,
    parameter int unsigned     NREGS   = RV_NREGS,
    parameter int unsigned     PEND_W  = 2,
    parameter int unsigned     SP_IDX  = RV_SP_IDX,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(SP_RESET),
    localparam int unsigned    AW      = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   addr_rs1,
    input  logic [AW-1:0]   addr_rs2,
    output logic [XLEN-1:0] data_rs1,
    output logic [XLEN-1:0] data_rs2,
    output logic            busy_rs1,
    output logic            busy_rs2,
    input  logic            issue_valid,
    input  logic [AW-1:0]   addr_issue,
    output logic            issue_ready,
    input  logic            write_enable,
    input  logic [AW-1:0]   addr_rd,
    input  logic [XLEN-1:0] data_rd,
    output logic            pend_err
);

    localparam logic [AW-1:0] X0 = AW'(RV_X0_IDX);

    logic [XLEN-1:0]   regs [NREGS];
    logic [PEND_W-1:0] pc   [NREGS];
    logic [NREGS-1:0]  inc_v;
    logic [NREGS-1:0]  dec_v;
    logic [NREGS-1:0]  at_max_v;
    logic [NREGS-1:0]  nonzero_v;
    logic [NREGS-1:0]  underflow_v;

    logic wb_hit;
    logic retire_to_issue;
    logic issue_fire;
    logic hit_rs1;
    logic hit_rs2;

    assign wb_hit          = write_enable && (addr_rd != X0);
    assign retire_to_issue = wb_hit && (addr_rd == addr_issue);

    // A saturated counter can still accept an issue when a retire to the
    // same register frees a slot in the same cycle.
    assign issue_ready = (addr_issue == X0) || !at_max_v[addr_issue] || retire_to_issue;
    assign issue_fire  = issue_valid && issue_ready && (addr_issue != X0);

    // One-hot issue/retire strobes per register; x0 never counts.
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int unsigned r = 1; r < NREGS; r++) begin
            inc_v[r] = issue_fire && (addr_issue == AW'(r));
            dec_v[r] = wb_hit && (addr_rd == AW'(r));
        end
    end

    // x0 has no counter.
    assign pc[0]          = '0;
    assign at_max_v[0]    = 1'b0;
    assign nonzero_v[0]   = 1'b0;
    assign underflow_v[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_pend
        reg_pend_counter #(
            .W (PEND_W)
        ) u_cnt (
            .clock     (clock),
            .reset     (reset),
            .inc       (inc_v[r]),
            .dec       (dec_v[r]),
            .count     (pc[r]),
            .at_max    (at_max_v[r]),
            .nonzero   (nonzero_v[r]),
            .underflow (underflow_v[r])
        );
    end

    // Architectural state; x0 stays zero because it is never written.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else if (wb_hit) begin
            regs[addr_rd] <= data_rd;
        end
    end

    // Sticky underflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_err <= 1'b0;
        end else if (|underflow_v) begin
            pend_err <= 1'b1;
        end
    end

    assign hit_rs1 = wb_hit && (addr_rs1 == addr_rd);
    assign hit_rs2 = wb_hit && (addr_rs2 == addr_rd);

    assign data_rs1 = hit_rs1 ? data_rd : regs[addr_rs1];
    assign data_rs2 = hit_rs2 ? data_rd : regs[addr_rs2];

    // Busy after discounting a same-cycle retire: a count of one that is
    // being retired right now is already clear.
    assign busy_rs1 = nonzero_v[addr_rs1] && !(hit_rs1 && (pc[addr_rs1] == PEND_W'(1)));
    assign busy_rs2 = nonzero_v[addr_rs2] && !(hit_rs2 && (pc[addr_rs2] == PEND_W'(1)));

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard with default parameters.
module tb_regfile_scoreboard;

    localparam logic [31:0] SP_EXP = 32'h0101_0000;

    logic        clock;
    logic        reset;
    logic [4:0]  addr_rs1;
    logic [4:0]  addr_rs2;
    logic [31:0] data_rs1;
    logic [31:0] data_rs2;
    logic        busy_rs1;
    logic        busy_rs2;
    logic        issue_valid;
    logic [4:0]  addr_issue;
    logic        issue_ready;
    logic        write_enable;
    logic [4:0]  addr_rd;
    logic [31:0] data_rd;
    logic        pend_err;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_scoreboard dut (
        .clock        (clock),
        .reset        (reset),
        .addr_rs1     (addr_rs1),
        .addr_rs2     (addr_rs2),
        .data_rs1     (data_rs1),
        .data_rs2     (data_rs2),
        .busy_rs1     (busy_rs1),
        .busy_rs2     (busy_rs2),
        .issue_valid  (issue_valid),
        .addr_issue   (addr_issue),
        .issue_ready  (issue_ready),
        .write_enable (write_enable),
        .addr_rd      (addr_rd),
        .data_rd      (data_rd),
        .pend_err     (pend_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Step past the next rising edge; inputs change and checks happen mid-cycle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        issue_valid  = 1'b0;
        write_enable = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        addr_rs1     = 5'd2;
        addr_rs2     = 5'd5;
        issue_valid  = 1'b0;
        addr_issue   = 5'd0;
        write_enable = 1'b0;
        addr_rd      = 5'd0;
        data_rd      = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // 1. reset state
        check("rst_x2",       data_rs1,    SP_EXP);
        check("rst_x5",       data_rs2,    32'h0);
        check("rst_pend_err", 32'(pend_err), 32'h0);
        check("rst_busy1",    32'(busy_rs1), 32'h0);
        check("rst_busy2",    32'(busy_rs2), 32'h0);
        check("rst_ready",    32'(issue_ready), 32'h1);

        // 2. issue x5 once, then write it with bypass on rs1
        issue_valid = 1'b1; addr_issue = 5'd5;
        tick();
        idle();
        addr_rs1 = 5'd5;
        #1;
        check("x5_busy_pre",  32'(busy_rs1), 32'h1);
        write_enable = 1'b1; addr_rd = 5'd5; data_rd = 32'hDEAD_BEEF;
        #1;
        check("x5_bypass",    data_rs1, 32'hDEAD_BEEF);
        check("x5_busy_ret",  32'(busy_rs1), 32'h0);
        tick();
        idle();
        #1;
        check("x5_stored",    data_rs1, 32'hDEAD_BEEF);
        check("x5_pend_err",  32'(pend_err), 32'h0);
        addr_rs1 = 5'd0;
        write_enable = 1'b1; addr_rd = 5'd0; data_rd = 32'h0000_1234;
        #1;
        check("x0_no_bypass", data_rs1, 32'h0);
        tick();
        idle();
        #1;
        check("x0_stored",    data_rs1, 32'h0);
        check("x0_pend_err",  32'(pend_err), 32'h0);

        // 3. fill x7 to saturation, then drain
        addr_rs2 = 5'd7;
        issue_valid = 1'b1; addr_issue = 5'd7;
        #1;
        check("x7_ready1",    32'(issue_ready), 32'h1);
        check("x7_busy_same", 32'(busy_rs2), 32'h0);
        tick();
        check("x7_busy1",     32'(busy_rs2), 32'h1);
        tick();
        tick();
        check("x7_ready_full", 32'(issue_ready), 32'h0);
        tick();
        idle();
        write_enable = 1'b1; addr_rd = 5'd7; data_rd = 32'h0000_0077;
        #1;
        check("x7_busy_r3",   32'(busy_rs2), 32'h1);
        tick();
        check("x7_busy_r2",   32'(busy_rs2), 32'h1);
        tick();
        check("x7_busy_r1",   32'(busy_rs2), 32'h0);
        check("x7_bypass",    data_rs2, 32'h0000_0077);
        tick();
        idle();
        #1;
        check("x7_busy_done", 32'(busy_rs2), 32'h0);
        check("x7_pend_err",  32'(pend_err), 32'h0);

        // 4. x9 at max: simultaneous issue and retire keeps pc at 3
        addr_rs1 = 5'd9;
        issue_valid = 1'b1; addr_issue = 5'd9;
        tick();
        tick();
        tick();
        check("x9_full",      32'(issue_ready), 32'h0);
        write_enable = 1'b1; addr_rd = 5'd9; data_rd = 32'h0000_0009;
        #1;
        check("x9_ready_both", 32'(issue_ready), 32'h1);
        tick();
        write_enable = 1'b0;
        #1;
        check("x9_still_full", 32'(issue_ready), 32'h0);
        check("x9_busy",      32'(busy_rs1), 32'h1);
        idle();
        write_enable = 1'b1;
        tick();
        tick();
        check("x9_busy_last", 32'(busy_rs1), 32'h0);
        tick();
        idle();
        #1;
        check("x9_drained",   32'(busy_rs1), 32'h0);
        check("x9_pend_err",  32'(pend_err), 32'h0);

        // 5. retire x4 with an empty counter
        addr_rs1 = 5'd4;
        write_enable = 1'b1; addr_rd = 5'd4; data_rd = 32'h0000_4444;
        tick();
        idle();
        #1;
        check("x4_written",   data_rs1, 32'h0000_4444);
        check("x4_pend_err",  32'(pend_err), 32'h1);
        tick();
        tick();
        check("x4_sticky",    32'(pend_err), 32'h1);

        // 6. async reset mid-cycle with pc[3]=2 and x3 holding data
        addr_rs1 = 5'd3;
        addr_rs2 = 5'd2;
        issue_valid = 1'b1; addr_issue = 5'd3;
        tick();
        tick();
        write_enable = 1'b1; addr_rd = 5'd3; data_rd = 32'h0000_3333;
        tick();
        idle();
        #1;
        check("x3_busy",      32'(busy_rs1), 32'h1);
        check("x3_data",      data_rs1, 32'h0000_3333);
        reset = 1'b1;
        #1;
        check("ar_busy",      32'(busy_rs1), 32'h0);
        check("ar_pend_err",  32'(pend_err), 32'h0);
        check("ar_x3",        data_rs1, 32'h0);
        check("ar_x2",        data_rs2, SP_EXP);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_x3",  data_rs1, 32'h0);
        check("post_rst_busy", 32'(busy_rs1), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
